// File: rtl/fpmul_sched_pkg.sv
// Shared defaults, derived widths and the {valid, id} tag carried alongside
// each multiply through the fixed-latency datapath.
package fpmul_sched_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned W_DEF     = 32;
    localparam int unsigned LAT_DEF   = 3;
    localparam int unsigned DEPTH_DEF = 4;

    localparam int unsigned IDW_DEF  = $clog2(N_REQ_DEF);
    localparam int unsigned OCCW_DEF = $clog2(DEPTH_DEF + 1);

    // Tag id field is sized for up to 256 requesters; the top uses the low IDW bits.
    localparam int unsigned TAG_IDW = 8;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fpmul_result_fifo.sv
// Synchronous result FIFO, DEPTH x DW, with async active-low reset.
// Head data reads as zero while empty so the return port idles at zero.
module fpmul_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 34
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr, rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign wr      = wr_en_i && !full_o;
    assign rd      = rd_en_i && !empty_o;

    always_comb begin
        wptr_d = wr ? next_ptr(wptr_q) : wptr_q;
        rptr_d = rd ? next_ptr(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (wr && !rd) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!wr && rd) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/fpmul_scheduler.sv
// Round-robin issue of N_REQ requesters onto one shared fixed-latency multiplier,
// with a tag pipe and credit-protected result FIFO on the return path.
module fpmul_scheduler
    import fpmul_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned LAT   = LAT_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned IDW  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic             mul_valid,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [W-1:0]     mul_prod,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic [IDW-1:0]   res_id,
    output logic             busy
);

    localparam int unsigned OCCW = occ_width(DEPTH);

    logic [OCCW-1:0]  occ_q, occ_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found, accept, pop;
    logic [W-1:0]     gnt_a, gnt_b;

    logic             mul_valid_q;
    logic [W-1:0]     mul_a_q, mul_b_q;
    logic [IDW-1:0]   issue_id_q;
    tag_t             tag_q [LAT];

    logic             fifo_full, fifo_empty;
    logic [W+IDW-1:0] fifo_rdata;
    logic             unused_sigs;

    // First valid requester at or after ptr_q in modulo order.
    always_comb begin
        int unsigned j;
        logic [IDW-1:0] idx;
        j         = 0;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            idx = IDW'(j);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Reset gating keeps req_ready low while rst_n is asserted.
    assign accept = gnt_found && (occ_q < OCCW'(DEPTH)) && rst_n;
    assign pop    = res_valid && res_ready;

    always_comb begin
        req_ready = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (IDW'(i) == gnt_idx);
            if (IDW'(i) == gnt_idx) begin
                gnt_a = req_a[i*W +: W];
                gnt_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        occ_d = occ_q;
        if (accept && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!accept && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            occ_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            issue_id_q  <= '0;
        end else begin
            mul_valid_q <= accept;
            if (accept) begin
                mul_a_q    <= gnt_a;
                mul_b_q    <= gnt_b;
                issue_id_q <= gnt_idx;
            end
        end
    end

    // Tag pipe mirrors the datapath latency; its last stage qualifies mul_prod.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= mul_valid_q;
            tag_q[0].id    <= TAG_IDW'(issue_id_q);
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    fpmul_result_fifo #(
        .DEPTH (DEPTH),
        .DW    (W + IDW)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (tag_q[LAT-1].valid),
        .wr_data_i ({tag_q[LAT-1].id[IDW-1:0], mul_prod}),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Credits guarantee the FIFO never fills past DEPTH, so full is informational.
    assign unused_sigs = ^{fifo_full, tag_q[LAT-1].id};

    assign mul_valid          = mul_valid_q;
    assign mul_a              = mul_a_q;
    assign mul_b              = mul_b_q;
    assign res_valid          = !fifo_empty;
    assign {res_id, res_data} = fifo_rdata;
    assign busy               = (occ_q != '0);

endmodule

// File: tb/tb_fpmul_scheduler.sv
// Scoreboard bench: a request-level model predicts grants and credits, pushes expected
// results on accept; a monitor pops and compares on every result handshake.
module tb_fpmul_scheduler;

    localparam int LAT     = 3;
    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic         mul_valid, res_valid, res_ready, busy;
    logic [31:0]  mul_a, mul_b, mul_prod, res_data;
    logic [1:0]   res_id;

    logic [3:0]   c4_req_valid, c4_req_ready;
    logic [127:0] c4_req_a, c4_req_b;
    logic         c4_mul_valid, c4_res_valid, c4_res_ready, c4_busy;
    logic [31:0]  c4_mul_a, c4_mul_b, c4_mul_prod, c4_res_data;
    logic [1:0]   c4_res_id;

    logic [31:0]  dp [LAT];
    logic [31:0]  dp4 [LAT];

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          rdy;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_acc = 0;

    int          m_occ, m_ptr, m_g, m_j;
    logic        m_acc, m_issued;
    logic [3:0]  m_rdy;
    logic [31:0] m_a, m_b, ea, eb;
    logic        p_stall, exp_v;
    logic [31:0] p_data;
    logic [1:0]  p_id;
    exp_t        e;

    fpmul_scheduler #(.N_REQ(4), .W(32), .LAT(LAT), .DEPTH(DEPTH_A)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_prod(mul_prod), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    fpmul_scheduler #(.N_REQ(4), .W(32), .LAT(LAT), .DEPTH(DEPTH_B)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(c4_req_valid), .req_ready(c4_req_ready),
        .req_a(c4_req_a), .req_b(c4_req_b), .mul_valid(c4_mul_valid), .mul_a(c4_mul_a),
        .mul_b(c4_mul_b), .mul_prod(c4_mul_prod), .res_valid(c4_res_valid),
        .res_ready(c4_res_ready), .res_data(c4_res_data), .res_id(c4_res_id), .busy(c4_busy)
    );

    always #5 clk = ~clk;

    // Operands are restricted to short mantissas so a double product is exact in single.
    function automatic real s2d(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) d = {x[31], 63'd0};
        else d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        d = $realtobits(s2d(a) * s2d(b));
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = {1'($urandom), 8'($urandom_range(154, 100)), 8'($urandom), 15'd0};
        return v;
    endfunction

    // Datapath stand-ins: exact LAT-stage delay lines of a*b.
    always @(posedge clk) begin
        dp[0]  <= fmul(mul_a, mul_b);
        dp4[0] <= fmul(c4_mul_a, c4_mul_b);
        for (int i = 1; i < LAT; i++) begin
            dp[i]  <= dp[i-1];
            dp4[i] <= dp4[i-1];
        end
        cyc <= cyc + 1;
    end
    assign mul_prod    = dp[LAT-1];
    assign c4_mul_prod = dp4[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: round-robin over valid requesters, credits = accepted - popped.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            m_occ = 0; m_ptr = 0; m_issued = 1'b0; m_a = '0; m_b = '0;
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_mul_valid", 64'(mul_valid), 64'd0);
            chk("rst_res_valid", 64'(res_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end else begin
            m_g = -1;
            for (int k = 0; k < 4; k++) begin
                m_j = (m_ptr + k) % 4;
                if (m_g < 0 && req_valid[m_j]) m_g = m_j;
            end
            m_acc = (m_g >= 0) && (m_occ < DEPTH_A);
            m_rdy = m_acc ? (4'b0001 << m_g) : 4'b0000;
            chk("req_ready", 64'(req_ready), 64'(m_rdy));
            chk("mul_valid", 64'(mul_valid), 64'(m_issued));
            chk("mul_a", 64'(mul_a), 64'(m_a));
            chk("mul_b", 64'(mul_b), 64'(m_b));
            chk("busy", 64'(busy), 64'(m_occ != 0));
            if (m_acc) begin
                ea = req_a[m_g*32 +: 32];
                eb = req_b[m_g*32 +: 32];
                q.push_back('{id: 2'(m_g), data: fmul(ea, eb), rdy: cyc + 2 + LAT});
                m_ptr = (m_g + 1) % 4;
                m_a = ea; m_b = eb;
                n_acc++;
            end
            m_issued = m_acc;
            m_occ = m_occ + (m_acc ? 1 : 0) - ((res_valid && res_ready) ? 1 : 0);
        end
    end

    // Monitor: result presence, stall stability and in-order contents.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            p_stall = 1'b0;
        end else begin
            exp_v = 1'b0;
            if (q.size() > 0) exp_v = (q[0].rdy <= cyc);
            chk("res_valid", 64'(res_valid), 64'(exp_v));
            if (p_stall) begin
                chk("stall_data", 64'(res_data), 64'(p_data));
                chk("stall_id", 64'(res_id), 64'(p_id));
            end
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL res_spurious: got pop id %0d data %0h expected no result",
                             res_id, res_data);
                end else begin
                    e = q.pop_front();
                    chk("res_id", 64'(res_id), 64'(e.id));
                    chk("res_data", 64'(res_data), 64'(e.data));
                end
            end
            p_stall = res_valid && !res_ready;
            p_data = res_data;
            p_id = res_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = rand_op();
            req_b[i*32 +: 32] = rand_op();
        end
    endtask

    task automatic drain(input string name);
        req_valid = 4'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 60 && (busy || q.size() != 0); i++) tick();
        chk(name, 64'(busy), 64'd0);
    endtask

    initial begin
        int c0, cnt, start;
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int c0, cnt, start;
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        c4_req_valid = '0; c4_req_a = '0; c4_req_b = '0; c4_res_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // 1: single request from requester 2, 2.0 * 3.0.
        tick();
        res_ready = 1'b1;
        req_a[64 +: 32] = 32'h4000_0000;
        req_b[64 +: 32] = 32'h4040_0000;
        req_valid = 4'b0100;
        c0 = cyc;
        tick();
        req_valid = 4'b0;
        while (!res_valid && cyc < c0 + 20) tick();
        chk("t1_latency", 64'(cyc - c0), 64'(2 + LAT));
        chk("t1_res_data", 64'(res_data), 64'h40C0_0000);
        chk("t1_res_id", 64'(res_id), 64'd2);
        drain("t1_drain");

        // 2: all requesters valid, full throughput.
        rand_operands();
        req_valid = 4'b1111;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (|req_ready) cnt++;
            rand_operands();
        end
        chk("t2_throughput", 64'(cnt), 64'd16);
        drain("t2_drain");

        // 4: random requests with toggling res_ready, 20 operations.
        start = n_acc;
        for (int i = 0; i < 500 && (n_acc - start) < 20; i++) begin
            rand_operands();
            req_valid = 4'($urandom);
            res_ready = 1'($urandom);
            tick();
        end
        req_valid = 4'b0;
        chk("t4_op_count", 64'(n_acc - start >= 20), 64'd1);
        drain("t4_drain");

        // 6: wrap/skip from ptr = 2 with only requesters 1 and 3 valid.
        tick();
        rand_operands();
        req_valid = 4'b0010;
        #1;
        chk("t6_setup", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b1010;
        #1;
        chk("t6_grant0", 64'(req_ready), 64'b1000);
        tick();
        chk("t6_grant1", 64'(req_ready), 64'b0010);
        tick();
        chk("t6_grant2", 64'(req_ready), 64'b1000);
        tick();
        drain("t6_drain");

        // 5: reset with three operations in flight.
        tick();
        res_ready = 1'b0;
        rand_operands();
        req_valid = 4'b1111;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_req_ready", 64'(req_ready), 64'd0);
        chk("t5_mul_valid", 64'(mul_valid), 64'd0);
        chk("t5_mul_a", 64'(mul_a), 64'd0);
        chk("t5_res_valid", 64'(res_valid), 64'd0);
        chk("t5_res_data", 64'(res_data), 64'd0);
        chk("t5_res_id", 64'(res_id), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        req_valid = 4'b0;
        res_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk("t5_no_stale", 64'(res_valid), 64'd0);
        end
        req_valid = 4'b1111;
        #1;
        chk("t5_ptr_restart", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0;
        drain("t5_drain");

        // Random soak.
        for (int i = 0; i < 300; i++) begin
            rand_operands();
            req_valid = 4'($urandom);
            res_ready = ($urandom_range(9, 0) < 7);
            tick();
        end
        drain("soak_drain");

        // 3: credit backpressure on the DEPTH=4 instance.
        c4_req_a[31:0] = 32'h3F80_0000;
        c4_req_b[31:0] = 32'h4000_0000;
        c4_res_ready = 1'b0;
        c4_req_valid = 4'b0001;
        #1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (|c4_req_ready) cnt++;
            tick();
        end
        chk("t3_accepts", 64'(cnt), 64'd4);
        chk("t3_blocked", 64'(c4_req_ready), 64'd0);
        chk("t3_busy", 64'(c4_busy), 64'd1);
        chk("t3_res_valid", 64'(c4_res_valid), 64'd1);
        chk("t3_res_id", 64'(c4_res_id), 64'd0);
        chk("t3_res_data", 64'(c4_res_data), 64'h4000_0000);
        c4_res_ready = 1'b1;
        #1;
        chk("t3_no_same_cycle_reuse", 64'(c4_req_ready), 64'd0);
        tick();
        c4_res_ready = 1'b0;
        #1;
        chk("t3_accept_after_pop", 64'(c4_req_ready), 64'b0001);
        tick();
        chk("t3_mul_valid", 64'(c4_mul_valid), 64'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (|c4_req_ready) cnt++;
            tick();
        end
        chk("t3_no_more", 64'(cnt), 64'd0);
        c4_req_valid = 4'b0;
        c4_res_ready = 1'b1;
        repeat (12) tick();
        chk("t3_drain", 64'(c4_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
